// File: rtl/game_ctrl.sv
// Maze game sequencer: keypad edge detection, idle/countdown/play/result FSM,
// play timer and frame select for the dot-matrix datapath.
module game_ctrl #(
  parameter int PLAY_TIME = 30,
  parameter int COUNT_S   = 3,
  parameter int HOLD_S    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1s,
  input  logic [11:0] key,
  input  logic        collision,
  input  logic        goal,
  output logic [3:0]  move_req,
  output logic        player_rst,
  output logic [1:0]  disp_mode,
  output logic [5:0]  time_left,
  output logic [2:0]  state,
  output logic        beep,
  output logic        timeover
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    SUCCESS   = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t      state_q, state_n;
  logic [11:0] key_prev;
  logic [11:0] rise;
  logic [3:0]  sec_cnt, sec_n;
  logic [5:0]  time_n;
  logic [3:0]  move_n;
  logic        prst_n, beep_n, tover_n;
  logic [1:0]  disp_n;

  assign rise  = key & ~key_prev;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_prev   <= 12'hFFF;
      sec_cnt    <= 4'd0;
      time_left  <= 6'(PLAY_TIME);
      move_req   <= 4'd0;
      player_rst <= 1'b0;
      beep       <= 1'b0;
      timeover   <= 1'b0;
      disp_mode  <= 2'd0;
    end else begin
      state_q    <= state_n;
      key_prev   <= key;
      sec_cnt    <= sec_n;
      time_left  <= time_n;
      move_req   <= move_n;
      player_rst <= prst_n;
      beep       <= beep_n;
      timeover   <= tover_n;
      disp_mode  <= disp_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sec_n   = sec_cnt;
    time_n  = time_left;
    move_n  = 4'd0;
    prst_n  = 1'b0;
    beep_n  = 1'b0;
    tover_n = timeover;
    unique case (state_q)
      IDLE: begin
        time_n = 6'(PLAY_TIME);
        if (rise[4]) begin
          state_n = COUNTDOWN;
          sec_n   = 4'(COUNT_S);
          prst_n  = 1'b1;
          beep_n  = 1'b1;
        end
      end
      COUNTDOWN: begin
        // A false start wins over a tick arriving in the same cycle.
        if (|rise) begin
          state_n = FAIL;
          tover_n = 1'b0;
          sec_n   = 4'(HOLD_S);
          beep_n  = 1'b1;
        end else if (tick_1s) begin
          beep_n = 1'b1;
          sec_n  = sec_cnt - 4'd1;
          if (sec_cnt == 4'd1) state_n = PLAY;
        end
      end
      PLAY: begin
        if (collision) begin
          state_n = FAIL;
          tover_n = 1'b0;
          sec_n   = 4'(HOLD_S);
          beep_n  = 1'b1;
        end else if (goal) begin
          state_n = SUCCESS;
          sec_n   = 4'(HOLD_S);
          beep_n  = 1'b1;
        end else if (tick_1s && time_left == 6'd1) begin
          state_n = FAIL;
          time_n  = 6'd0;
          tover_n = 1'b1;
          sec_n   = 4'(HOLD_S);
          beep_n  = 1'b1;
        end else begin
          if (tick_1s && time_left != 6'd0) time_n = time_left - 6'd1;
          if (rise[1])      move_n = 4'b0001;
          else if (rise[7]) move_n = 4'b0010;
          else if (rise[3]) move_n = 4'b0100;
          else if (rise[5]) move_n = 4'b1000;
        end
      end
      SUCCESS, FAIL: begin
        if (tick_1s) begin
          sec_n = sec_cnt - 4'd1;
          if (sec_cnt == 4'd1) begin
            state_n = IDLE;
            tover_n = 1'b0;
            time_n  = 6'(PLAY_TIME);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    disp_n = 2'd0;
    unique case (state_n)
      IDLE:      disp_n = 2'd0;
      COUNTDOWN: disp_n = 2'd1;
      PLAY:      disp_n = 2'd1;
      SUCCESS:   disp_n = 2'd2;
      FAIL:      disp_n = 2'd3;
      default:   disp_n = 2'd0;
    endcase
  end

endmodule
